inst_decode_issue: RTL

//  Decode/issue stage upstream of the integer ALU. Accepts 32-bit RV64 instruction words from fetch
//  and drives the ALU's packed interface {regA, regB, opcode, regDest}. Holds back RAW/WAW hazards

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/inst_decode_issue_scoreboard.sv | 35 +++
 rtl/inst_decode_issue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 integer decode definitions: major opcodes, packed ALU
// opcodes, funct7 values and the decoded-instruction bundle.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_OP32     = 7'h3B;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [6:0] F7_ALT    = 7'h20;

    // {funct3, opcode} as seen by the ALU
    localparam logic [9:0] ALU_ADDI  = 10'h013;
    localparam logic [9:0] ALU_ADDIW = 10'h01B;
    localparam logic [9:0] ALU_ADD   = 10'h033;
    localparam logic [9:0] ALU_ADDW  = 10'h03B;
    localparam logic [9:0] ALU_XORI  = 10'h213;
    localparam logic [9:0] ALU_XOR   = 10'h233;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] regB;
        logic [9:0]  opcode;
        logic        uses_rs2;
        logic        legal;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] inst);
        decoded_t   d;
        logic [6:0] op;
        logic [6:0] f7;
        op         = inst[6:0];
        f7         = inst[31:25];
        d.rs1      = inst[19:15];
        d.rs2      = inst[24:20];
        d.rd       = inst[11:7];
        d.regB     = inst[31:20];
        d.opcode   = {inst[14:12], op};
        d.uses_rs2 = (op == OPC_OP) || (op == OPC_OP32);
        d.legal    = (op == OPC_OP_IMM) || (op == OPC_OP_IMM32) ||
                     (d.uses_rs2 && ((f7 == F7_BASE) ||
                                     (f7 == F7_MULDIV) ||
                                     (f7 == F7_ALT)));
        return d;
    endfunction

endpackage

// File: rtl/inst_decode_issue_scoreboard.sv
// Register busy bits for in-flight ALU writers; x0 is never busy.
// A set and a clear of the same register in one cycle leaves it busy.
module rv_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int IDXW     = $clog2(NUM_REGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_set_en,
    input  logic [IDXW-1:0]     i_set_reg,
    input  logic                i_clr_en,
    input  logic [IDXW-1:0]     i_clr_reg,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:1] r_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i_set_en && i_set_reg == IDXW'(i))
                    r_busy[i] <= 1'b1;
                else if (i_clr_en && i_clr_reg == IDXW'(i))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    assign o_busy = {r_busy, 1'b0};

endmodule

// File: rtl/inst_decode_issue.sv
// Decode/issue stage: single D-register, scoreboard hazard stall,
// trap on encodings the integer ALU cannot execute.
module inst_decode_issue
    import riscv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_fetch_valid,
    output logic            o_fetch_ready,
    input  logic [31:0]     i_fetch_inst,
    input  logic [XLEN-1:0] i_fetch_pc,
    input  logic            i_flush,
    output logic            o_alu_valid,
    output logic [4:0]      o_alu_regA,
    output logic [11:0]     o_alu_regB,
    output logic [9:0]      o_alu_opcode,
    output logic [4:0]      o_alu_regDest,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_reg,
    output logic            o_illegal_valid,
    output logic [31:0]     o_illegal_inst,
    output logic [XLEN-1:0] o_illegal_pc,
    input  logic            i_illegal_ack
);

    dec_state_e            r_state;
    dec_state_e            w_state_nxt;
    logic                  r_d_valid;
    logic [31:0]           r_d_inst;
    logic [XLEN-1:0]       r_d_pc;
    logic                  r_ill_valid;
    logic [31:0]           r_ill_inst;
    logic [XLEN-1:0]       r_ill_pc;

    decoded_t              w_dec;
    logic [NUM_REGS-1:0]   w_busy;
    logic                  w_run;
    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_trap_enter;
    logic                  w_ready;
    logic                  w_fire;

    assign w_dec    = decode(r_d_inst);
    assign w_run    = (r_state == RUN);
    assign w_hazard = w_busy[w_dec.rs1] |
                      (w_dec.uses_rs2 & w_busy[w_dec.rs2]) |
                      w_busy[w_dec.rd];

    assign w_issue      = ~i_reset & r_d_valid & w_dec.legal &
                          ~w_hazard & w_run & ~i_flush;
    assign w_trap_enter = ~i_reset & r_d_valid & ~w_dec.legal &
                          w_run & ~i_flush;
    // Combinational gate on reset keeps ready low while reset is held
    assign w_ready      = ~i_reset & w_run & ~i_flush &
                          (~r_d_valid | w_issue);
    assign w_fire       = i_fetch_valid & w_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (w_trap_enter) w_state_nxt = TRAP;
            TRAP:    if (i_illegal_ack | i_flush) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_d_valid <= 1'b0;
            r_d_inst  <= '0;
            r_d_pc    <= '0;
        end else if (i_flush) begin
            r_d_valid <= 1'b0;
        end else if (w_fire) begin
            r_d_valid <= 1'b1;
            r_d_inst  <= i_fetch_inst;
            r_d_pc    <= i_fetch_pc;
        end else if (w_issue | w_trap_enter) begin
            r_d_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ill_valid <= 1'b0;
            r_ill_inst  <= '0;
            r_ill_pc    <= '0;
        end else if (w_trap_enter) begin
            r_ill_valid <= 1'b1;
            r_ill_inst  <= r_d_inst;
            r_ill_pc    <= r_d_pc;
        end else if (!w_run && (i_illegal_ack || i_flush)) begin
            r_ill_valid <= 1'b0;
        end
    end

    rv_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_set_en  (w_issue),
        .i_set_reg (w_dec.rd),
        .i_clr_en  (i_wb_valid),
        .i_clr_reg (i_wb_reg),
        .o_busy    (w_busy)
    );

    assign o_fetch_ready   = w_ready;
    assign o_alu_valid     = w_issue;
    assign o_alu_regA      = w_dec.rs1;
    assign o_alu_regB      = w_dec.regB;
    assign o_alu_opcode    = w_dec.opcode;
    assign o_alu_regDest   = w_dec.rd;
    assign o_illegal_valid = r_ill_valid;
    assign o_illegal_inst  = r_ill_inst;
    assign o_illegal_pc    = r_ill_pc;

endmodule
